// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared data-memory sizing and dump-engine state encoding
//
// Purpose: common definitions for blocks that sit on the CPU data-memory port.
//   DUMP_ADDR_W / DUMP_DATA_W : default address and word widths
//   MEM_WORDS                 : number of data-memory words
//   dump_state_e              : readback engine states
package cpu_mem_pkg;

  localparam int DUMP_ADDR_W = 10;
  localparam int DUMP_DATA_W = 32;
  localparam int MEM_WORDS   = 1 << DUMP_ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    CAPT,
    SEND,
    FIN
  } dump_state_e;

endpackage

// File: rtl/data_mem_dump_reader.sv
// rtl/data_mem_dump_reader.sv - streams a contiguous range of data-memory words out with their addresses
//
// Purpose: after the CPU halts, read base_addr..base_addr+count-1 (wrapping) from
// the synchronous data-memory read port and present each word on a valid/ready
// output, tagged with its source address.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start               : one-cycle dump request, honoured only when idle
//   base_addr, count    : first word and word count (0..MEM_WORDS), captured on start
//   mem_rd_en, mem_addr : read strobe/address to the data memory
//   mem_rdata           : read data, valid the cycle after mem_rd_en
//   out_valid/out_ready : output handshake
//   out_data, out_addr  : streamed word and its address
//   busy, done          : dump in progress, one-cycle completion pulse
module data_mem_dump_reader
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = DUMP_ADDR_W,
  parameter int DATA_W = DUMP_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done
);

  dump_state_e       state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   rem;
  logic [ADDR_W-1:0] ptr_inc;

  // Natural ADDR_W-bit rollover gives the 1023 -> 0 wrap.
  assign ptr_inc = ptr + ADDR_W'(1);

  // All outputs are registered; the read strobe is raised on the edge that
  // enters REQ so it lines up with that state exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      rem       <= '0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (count != '0) begin
              ptr       <= base_addr;
              rem       <= count;
              mem_rd_en <= 1'b1;
              mem_addr  <= base_addr;
              state     <= REQ;
            end else begin
              state <= FIN;
            end
          end
        end
        REQ: begin
          mem_rd_en <= 1'b0;
          state     <= CAPT;
        end
        CAPT: begin
          out_data  <= mem_rdata;
          out_addr  <= ptr;
          out_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            rem       <= rem - (ADDR_W + 1)'(1);
            ptr       <= ptr_inc;
            if (rem == (ADDR_W + 1)'(1)) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              mem_rd_en <= 1'b1;
              mem_addr  <= ptr_inc;
              state     <= REQ;
            end
          end
        end
        FIN: begin
          // Arriving from the last handshake, done is already high. A zero-count
          // dump arrives with done low and raises it here, one cycle later.
          if (done) begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_dump_reader.sv
// tb/tb_data_mem_dump_reader.sv - directed self-checking bench for data_mem_dump_reader
module tb_data_mem_dump_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] count;
  logic        mem_rd_en;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [9:0]  out_addr;
  logic        busy;
  logic        done;

  data_mem_dump_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] hs_data [$];
  logic [9:0]  hs_addr [$];
  int          hs_cyc  [$];
  int          rd_cyc  [$];
  int          done_cnt;
  int          done_cyc;
  int          valid_seen;
  int          start_cyc;

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_rd_en) rd_cyc.push_back(cyc);
      if (out_valid) valid_seen++;
      if (out_valid && out_ready) begin
        hs_data.push_back(out_data);
        hs_addr.push_back(out_addr);
        hs_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    hs_data.delete();
    hs_addr.delete();
    hs_cyc.delete();
    rd_cyc.delete();
    done_cnt   = 0;
    valid_seen = 0;
  endtask

  task automatic do_start(input logic [9:0] b, input logic [10:0] c);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = b;
    count     = c;
    @(posedge clk);
    #1;
    start     = 1'b0;
    start_cyc = cyc - 1;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && done_cnt == 0; i++) @(negedge clk);
    check("done_seen", 32'(done_cnt != 0), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_stream(input string tag, input int n, input logic [31:0] d [5],
                              input logic [9:0] a [5]);
    check({tag, "_count"}, hs_data.size(), n);
    for (int i = 0; i < n && i < hs_data.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), hs_data[i], d[i]);
      check($sformatf("%s_addr%0d", tag, i), 32'(hs_addr[i]), 32'(a[i]));
    end
  endtask

  logic [31:0] exp_d [5];
  logic [9:0]  exp_a [5];

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    count     = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
    mem[0] = 32'd3; mem[1] = 32'd7; mem[2] = 32'd9; mem[3] = 32'd11; mem[4] = 32'd12;
    mem[100] = 32'h0000_0100;
    exp_d = '{32'd3, 32'd7, 32'd9, 32'd11, 32'd12};
    exp_a = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd4};

    repeat (3) @(negedge clk);
    check("rst_rd_en", 32'(mem_rd_en), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_data", out_data, 0);
    check("rst_addr", 32'(out_addr), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Sorted-array readback at full rate
    clear_mon();
    do_start(10'd0, 11'd5);
    @(negedge clk);
    check("t1_busy", 32'(busy), 1);
    wait_done();
    check_stream("t1", 5, exp_d, exp_a);
    check("t1_rd_lat", 32'(rd_cyc[0] - start_cyc), 1);
    check("t1_valid_lat", 32'(hs_cyc[0] - rd_cyc[0]), 2);
    for (int i = 1; i < 5; i++) check($sformatf("t1_gap%0d", i), 32'(hs_cyc[i] - hs_cyc[i-1]), 3);
    check("t1_done_cnt", 32'(done_cnt), 1);
    check("t1_done_lat", 32'(done_cyc - hs_cyc[4]), 1);
    check("t1_rd_cnt", 32'(rd_cyc.size()), 5);
    check("t1_busy_end", 32'(busy), 0);

    // Backpressure on word 2
    clear_mon();
    do_start(10'd0, 11'd5);
    for (int i = 0; i < 100 && hs_data.size() < 2; i++) @(negedge clk);
    @(posedge clk);
    #1 out_ready = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("t2_stall_valid%0d", i), 32'(out_valid), 1);
      check($sformatf("t2_stall_data%0d", i), out_data, 32'd9);
      check($sformatf("t2_stall_addr%0d", i), 32'(out_addr), 2);
      check($sformatf("t2_stall_rd%0d", i), 32'(mem_rd_en), 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done();
    check_stream("t2", 5, exp_d, exp_a);
    check("t2_rd_cnt", 32'(rd_cyc.size()), 5);
    check("t2_done_cnt", 32'(done_cnt), 1);

    // Zero count
    clear_mon();
    do_start(10'd7, 11'd0);
    wait_done();
    check("t4_done_lat", 32'(done_cyc - start_cyc), 2);
    check("t4_done_cnt", 32'(done_cnt), 1);
    check("t4_rd_cnt", 32'(rd_cyc.size()), 0);
    check("t4_valid", 32'(valid_seen), 0);

    // Start while busy is ignored
    clear_mon();
    do_start(10'd0, 11'd5);
    repeat (4) @(posedge clk);
    do_start(10'd100, 11'd3);
    @(negedge clk);
    check("t5_busy", 32'(busy), 1);
    wait_done();
    check_stream("t5", 5, exp_d, exp_a);
    check("t5_done_cnt", 32'(done_cnt), 1);

    // Asynchronous reset while in SEND
    clear_mon();
    out_ready = 1'b0;
    do_start(10'd1, 11'd4);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    check("t6_in_send", 32'(out_valid), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_valid", 32'(out_valid), 0);
    check("t6_data", out_data, 0);
    check("t6_addr", 32'(out_addr), 0);
    check("t6_rd_en", 32'(mem_rd_en), 0);
    check("t6_mem_addr", 32'(mem_addr), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_done", 32'(done), 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_no_done", 32'(done_cnt), 0);
    check("t6_idle_busy", 32'(busy), 0);
    clear_mon();
    @(posedge clk);
    #1 out_ready = 1'b1;
    do_start(10'd3, 11'd2);
    wait_done();
    check("t6_count", hs_data.size(), 2);
    check("t6_d0", hs_data[0], 32'd11);
    check("t6_a0", 32'(hs_addr[0]), 3);
    check("t6_d1", hs_data[1], 32'd12);
    check("t6_a1", 32'(hs_addr[1]), 4);

    // Wrap-around at the top of memory
    mem[1022] = 32'h0000_AAAA;
    mem[1023] = 32'h0000_BBBB;
    mem[0]    = 32'h0000_CCCC;
    clear_mon();
    do_start(10'd1022, 11'd3);
    wait_done();
    exp_d = '{32'h0000_AAAA, 32'h0000_BBBB, 32'h0000_CCCC, 32'd0, 32'd0};
    exp_a = '{10'd1022, 10'd1023, 10'd0, 10'd0, 10'd0};
    check_stream("t3", 3, exp_d, exp_a);
    check("t3_done_cnt", 32'(done_cnt), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_dump_reader.md
Name: data_mem_dump_reader

Overview:
- Readback engine for the CPU data memory; the read-side counterpart of the testbench/host load path (write_data, address, inst_data).
- After a program halts, it reads a contiguous range of data-memory words through a synchronous read port and streams them out on a valid/ready interface.
- Each word is tagged with its source address.
- Sits beside the data memory and is muxed onto its address/read port while the CPU is held in reset.

Parameters:
- ADDR_W, 10, data-memory address width (1024 words).
- DATA_W, 32, data word width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a dump; sampled only in IDLE.
- base_addr  input  ADDR_W  first word address; captured on start.
- count  input  ADDR_W+1  number of words to read, 0..1024; captured on start.
- mem_rd_en  output  1  read strobe to the data memory.
- mem_addr  output  ADDR_W  read address to the data memory.
- mem_rdata  input  DATA_W  read data, valid exactly one cycle after mem_rd_en.
- out_valid  output  1  out_data and out_addr hold a word.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- out_data  output  DATA_W  streamed word.
- out_addr  output  ADDR_W  memory address of out_data.
- busy  output  1  high from the cycle after start until done.
- done  output  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset is asynchronous and active-high. The clock is clk. On reset:
  - state=IDLE.
  - mem_rd_en, out_valid, busy and done all 0.
  - mem_addr, out_data and out_addr all 0.
  - Internal pointer and remaining-count registers cleared.
- States: IDLE, REQ, CAPT, SEND, FIN.
- IDLE:
  - start=1 with count>0: latch ptr=base_addr and rem=count, then go to REQ. busy=1 from the next cycle.
  - start=1 with count=0: go to FIN; no memory access occurs.
- REQ: assert mem_rd_en=1 and mem_addr=ptr for exactly one cycle, then go to CAPT.
- CAPT:
  - Register out_data<=mem_rdata and out_addr<=ptr.
  - Set out_valid=1, then go to SEND.
- SEND:
  - Hold out_valid, out_data and out_addr stable until out_ready=1.
  - On handshake: out_valid<=0, rem<=rem-1, ptr<=ptr+1 (mod 2^ADDR_W, so 1023 wraps to 0).
  - If rem==1 at the handshake, go to FIN; otherwise go to REQ.
- FIN: done=1 for one cycle, busy<=0, then go to IDLE.
- Latency:
  - start to first mem_rd_en: 1 cycle.
  - mem_rd_en to out_valid rising: 2 cycles.
  - Minimum period is 3 cycles per word when out_ready is held high.
- mem_rd_en is never asserted outside REQ; mem_addr holds its last value otherwise.
- start while busy is ignored; base_addr and count are not resampled.
- out_ready while out_valid=0 has no effect.
- A reset asserted mid-dump aborts immediately, returns every output to its reset value, and emits no done pulse.
- count=1024 reads every word exactly once; ptr wraps back to base_addr at the end.

Decomposition:
- Shared package cpu_mem_pkg holds:
  - ADDR_W and DATA_W defaults.
  - MEM_WORDS = 1024.
  - The dump state enum (IDLE, REQ, CAPT, SEND, FIN).
- No sub-module. The output holding register is a plain always block inside data_mem_dump_reader.

Test Plan:
- Sorted-array readback: preload memory[0..4] = 3,7,9,11,12; start with base=0, count=5, out_ready=1.
  - Expect out_data 3,7,9,11,12 with out_addr 0..4.
  - Each word 3 cycles apart.
  - done pulses once, 1 cycle after the last handshake.
- Backpressure: same memory, out_ready driven low for 4 cycles while word 2 is presented.
  - out_valid, out_data=9 and out_addr=2 stay stable throughout.
  - No mem_rd_en is asserted during the stall; the sequence is unchanged.
- Wrap-around: memory[1022]=0xAAAA, memory[1023]=0xBBBB, memory[0]=0xCCCC; base=1022, count=3.
  - Expect out_addr 1022, 1023, 0 with the matching data.
- Zero count: start with count=0.
  - done pulses 2 cycles after start.
  - mem_rd_en and out_valid are never asserted.
- Start while busy: a second start with base=100 mid-dump is ignored; the original 5-word stream completes unchanged.
- Reset mid-operation: assert rst asynchronously (mid-cycle) while in SEND.
  - All outputs go to 0 immediately; done is not pulsed.
  - After rst is released, a new start with count=2 streams normally.
